cbus_arbiter: RTL and testbench

// - N-to-1 arbiter between the per-cache cbus masters (ICache, DCache, uncached path) and the single

---
 rtl/cbus_arbiter_if.sv | 45 ++++
 rtl/cbus_arbiter.sv | 98 +++++++++
 tb/tb_cbus_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// cbus request/response types and the bundled per-master/bridge-side bus seen by cbus_arbiter.
// slave modport is the arbiter's view, master modport is the surrounding system's view.
package cbus_pkg;

  typedef logic [3:0] mlen_t;
  typedef logic [2:0] msize_t;

  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int unsigned NUM_PORTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  [NUM_PORTS-1:0] ireqs;
  cbus_resp_t [NUM_PORTS-1:0] oresps;
  cbus_req_t                  oreq;
  cbus_resp_t                 iresp;

  modport slave  (input ireqs, iresp, output oresps, oreq);
  modport master (output ireqs, iresp, input oresps, oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// N-to-1 burst-locked cbus arbiter: one master owns the bridge from grant until the last beat.
// Round-robin by default; define CBUS_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.slave bus,
  output logic          busy,
  output logic          proto_err
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [IdxW-1:0] grant_q;
  logic [3:0]      cnt_q;
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
  logic [IdxW-1:0] rr_q;
`endif

  logic [IdxW-1:0] winner;
  logic            any_valid;
  int unsigned     idx;

  // First valid index, scanning upward from the priority start and wrapping.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
      idx = k;
`else
      idx = (32'(rr_q) + k) % NUM_PORTS;
`endif
      if (!any_valid && bus.ireqs[IdxW'(idx)].valid) begin
        winner    = IdxW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
      rr_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            grant_q <= winner;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // The bridge owns burst termination; a miscounted last still ends the burst.
          if (bus.iresp.ready) begin
            if (bus.iresp.last) begin
              state_q <= StIdle;
              cnt_q   <= '0;
`ifndef CBUS_ARB_FIXED_PRIORITY_EN
              rr_q    <= (grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StBusy);
  assign proto_err = busy && bus.iresp.ready && bus.iresp.last &&
                     (cnt_q != bus.ireqs[grant_q].len);

  // oreq depends only on state and the granted request, never on iresp.
  always_comb begin
    bus.oreq   = '0;
    bus.oresps = '0;
    if (state_q == StBusy) begin
      bus.oreq            = bus.ireqs[grant_q];
      bus.oresps[grant_q] = bus.iresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a transaction-level ownership model checked every cycle,
// plus hand-computed checkpoints for grant order, beat counts and protocol-error pulses.
`timescale 1ns/1ps
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int unsigned N = 2;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic proto_err;

  cbus_arbiter_if #(.NUM_PORTS(N)) bus ();

  cbus_arbiter #(.NUM_PORTS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the bridge, who is preferred next, beats accepted so far.
  int owner  = -1;
  int pref   = 0;
  int nbeats = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    int p;
    if (reset) begin
      owner  = -1;
      pref   = 0;
      nbeats = 0;
      chk_en = 1'b1;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
        p = k;
`else
        p = (pref + k) % N;
`endif
        if (owner < 0 && bus.ireqs[p].valid) owner = p;
      end
      nbeats = 0;
    end else if (bus.iresp.ready) begin
      if (bus.iresp.last) begin
        pref   = (owner + 1) % N;
        owner  = -1;
        nbeats = 0;
      end else begin
        nbeats++;
      end
    end
  end

  int beats_seen [N] = '{default: 0};
  int pe_seen = 0;

  always @(negedge clk) begin
    cbus_req_t            er;
    cbus_resp_t [N-1:0]   ers;
    bit                   eb;
    bit                   epe;
    if (chk_en) begin
      eb  = (owner >= 0);
      er  = '0;
      ers = '0;
      epe = 1'b0;
      if (eb) begin
        er         = bus.ireqs[owner];
        ers[owner] = bus.iresp;
        epe = bus.iresp.ready && bus.iresp.last &&
              ((nbeats % 16) != int'(bus.ireqs[owner].len));
      end
      check("oreq", 128'(bus.oreq), 128'(er));
      check("oresps", 128'(bus.oresps), 128'(ers));
      check("busy", 128'(busy), 128'(eb));
      check("proto_err", 128'(proto_err), 128'(epe));
      for (int p = 0; p < N; p++) beats_seen[p] += int'(bus.oresps[p].ready);
      pe_seen += int'(proto_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit v, input logic [31:0] addr, input mlen_t len);
    bus.ireqs[p].valid    = v;
    bus.ireqs[p].is_write = 1'b0;
    bus.ireqs[p].size     = 3'd2;
    bus.ireqs[p].addr     = addr;
    bus.ireqs[p].strobe   = 4'h0;
    bus.ireqs[p].data     = 32'h0;
    bus.ireqs[p].len      = len;
  endtask

  task automatic beat(input bit last, input logic [31:0] d);
    bus.iresp.ready = 1'b1;
    bus.iresp.last  = last;
    bus.iresp.data  = d;
    tick();
    bus.iresp = '0;
  endtask

  task automatic burst(input int n, input logic [31:0] base);
    for (int b = 1; b <= n; b++) beat(b == n, base + 32'(b));
  endtask

  int b0;
  int b1;
  int pe0;
  int w2;

  initial begin
    reset     = 1'b1;
    bus.ireqs = '0;
    bus.iresp = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset.
    repeat (10) tick();
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    check("idle_oresps", 128'(bus.oresps), 128'(0));

    // Port0 16-beat read, bridge ready every cycle.
    set_req(0, 1'b1, 32'h8000_0040, MLEN16);
    #1;
    check("grant_not_combinational", 128'(bus.oreq.valid), 128'(0));
    tick();
    check("grant_one_cycle", 128'(bus.oreq.valid), 128'(1));
    check("grant_addr", 128'(bus.oreq.addr), 128'(32'h8000_0040));
    b0 = beats_seen[0];
    b1 = beats_seen[1];
    burst(16, 32'hA000_0000);
    set_req(0, 1'b0, 32'h0, MLEN1);
    check("busy_after_last", 128'(busy), 128'(0));
    check("p0_beats16", 128'(beats_seen[0] - b0), 128'(16));
    check("p1_no_beats", 128'(beats_seen[1] - b1), 128'(0));

    // Contention from a fresh reset: port0 first, then round-robin (or fixed priority).
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b0 = beats_seen[0];
    b1 = beats_seen[1];
    set_req(0, 1'b1, A0, MLEN4);
    set_req(1, 1'b1, A1, MLEN4);
    tick();
    check("first_winner", 128'(bus.oreq.addr), 128'(A0));
    burst(4, 32'hB000_0000);
    check("gap_after_first", 128'(busy), 128'(0));
    tick();
`ifdef CBUS_ARB_FIXED_PRIORITY_EN
    w2 = 0;
`else
    w2 = 1;
`endif
    check("second_winner", 128'(bus.oreq.addr), 128'(w2 == 1 ? A1 : A0));
    burst(4, 32'hB100_0000);
    set_req(w2, 1'b0, 32'h0, MLEN1);
    check("gap_after_second", 128'(busy), 128'(0));
    tick();
    check("third_winner", 128'(bus.oreq.addr), 128'(w2 == 1 ? A0 : A1));
    burst(4, 32'hB200_0000);
    set_req(1 - w2, 1'b0, 32'h0, MLEN1);
    check("contention_p0_beats", 128'(beats_seen[0] - b0), 128'(8));
    check("contention_p1_beats", 128'(beats_seen[1] - b1), 128'(4));

    // Port0 requests while port1 holds the bridge.
    set_req(1, 1'b1, A1, MLEN8);
    tick();
    check("p1_granted", 128'(bus.oreq.addr), 128'(A1));
    b0 = beats_seen[0];
    for (int b = 1; b <= 8; b++) begin
      if (b == 3) set_req(0, 1'b1, A0, MLEN1);
      beat(b == 8, 32'hC000_0000 + 32'(b));
    end
    set_req(1, 1'b0, 32'h0, MLEN1);
    check("p0_starved_during_p1", 128'(beats_seen[0] - b0), 128'(0));
    check("gap_after_p1", 128'(busy), 128'(0));
    tick();
    check("p0_granted_next", 128'(bus.oreq.addr), 128'(A0));
    pe0 = pe_seen;
    beat(1'b1, 32'hC100_0000);
    set_req(0, 1'b0, 32'h0, MLEN1);
    check("single_beat_done", 128'(busy), 128'(0));
    check("single_beat_no_err", 128'(pe_seen - pe0), 128'(0));

    // Early last on beat 8 of a 16-beat burst.
    set_req(0, 1'b1, A0, MLEN16);
    tick();
    pe0 = pe_seen;
    for (int b = 1; b <= 7; b++) beat(1'b0, 32'hD000_0000 + 32'(b));
    bus.iresp.ready = 1'b1;
    bus.iresp.last  = 1'b1;
    bus.iresp.data  = 32'hD000_0008;
    #1;
    check("early_last_err", 128'(proto_err), 128'(1));
    tick();
    bus.iresp = '0;
    set_req(0, 1'b0, 32'h0, MLEN1);
    check("early_last_idle", 128'(busy), 128'(0));
    check("early_last_one_pulse", 128'(pe_seen - pe0), 128'(1));

    // Reset during beat 5 of a port0 burst.
    set_req(0, 1'b1, A0, MLEN16);
    tick();
    for (int b = 1; b <= 4; b++) beat(1'b0, 32'hE000_0000 + 32'(b));
    bus.iresp.ready = 1'b1;
    bus.iresp.data  = 32'hE000_0005;
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    bus.iresp = '0;
    check("reset_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    set_req(0, 1'b0, 32'h0, MLEN1);
    tick();
    // Pointer must be back at port0 after reset.
    set_req(0, 1'b1, A0, MLEN1);
    set_req(1, 1'b1, A1, MLEN1);
    tick();
    check("post_reset_winner", 128'(bus.oreq.addr), 128'(A0));
    beat(1'b1, 32'hF000_0001);
    set_req(0, 1'b0, 32'h0, MLEN1);
    set_req(1, 1'b0, 32'h0, MLEN1);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
